// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the dec_exec decode/execute slice: the default data
// width, the 4-bit opcode map, the RUN/FLUSH/HALT state encoding and a small
// opcode-classification helper.
// Ports: none (package).
// Optional build macro used by importers: DEC_EXEC_DBG_EN.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Opcodes 0xA..0xE are not assigned to any instruction.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/dec_exec_if.sv
// -----------------------------------------------------------------------------
// dec_exec_if
// Groups the instruction bus into dec_exec and the status/writeback bus out of
// it.
//   master : drives in_valid, Op, Rs, Rt, Rd, imm; observes the outputs.
//   slave  : dec_exec side; drives br_taken, br_addr, wb_en, wb_idx, wb_data,
//            zero, carry, halted, illegal.
// -----------------------------------------------------------------------------
interface dec_exec_if import cpu_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [3:0]        Op;
  logic [1:0]        Rs;
  logic [1:0]        Rt;
  logic [1:0]        Rd;
  logic [7:0]        imm;

  logic              br_taken;
  logic [7:0]        br_addr;
  logic              wb_en;
  logic [1:0]        wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              zero;
  logic              carry;
  logic              halted;
  logic              illegal;

  modport master (
    output in_valid, Op, Rs, Rt, Rd, imm,
    input  br_taken, br_addr, wb_en, wb_idx, wb_data, zero, carry, halted, illegal
  );

  modport slave (
    input  in_valid, Op, Rs, Rt, Rd, imm,
    output br_taken, br_addr, wb_en, wb_idx, wb_data, zero, carry, halted, illegal
  );

endinterface

// File: rtl/regfile4x8.sv
// -----------------------------------------------------------------------------
// regfile4x8
// Four-entry register file: two combinational read ports (A, B), one write
// port committed on the rising clock edge, asynchronous active-high reset
// clearing every entry.
// With DEC_EXEC_DBG_EN defined a third combinational read port (C) exists for
// debug observation.
// Ports: clk, rst, i_ra_idx/o_ra_data, i_rb_idx/o_rb_data, i_we/i_wa/i_wd,
//        [i_rc_idx/o_rc_data].
// -----------------------------------------------------------------------------
module regfile4x8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_ra_idx,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [1:0]        i_rb_idx,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic              i_we,
  input  logic [1:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd
`ifdef DEC_EXEC_DBG_EN
  ,
  input  logic [1:0]        i_rc_idx,
  output logic [DATA_W-1:0] o_rc_data
`endif
);

  logic [DATA_W-1:0] r_mem [4];

  // Register storage: cleared on reset, single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data = r_mem[i_ra_idx];
  assign o_rb_data = r_mem[i_rb_idx];

`ifdef DEC_EXEC_DBG_EN
  assign o_rc_data = r_mem[i_rc_idx];
`endif

endmodule

// File: rtl/dec_exec.sv
// -----------------------------------------------------------------------------
// dec_exec
// Single-cycle decode/execute stage for a 4-register toy CPU. An instruction
// presented with in_valid in RUN is decoded, its operands read from the
// register file, and its result and flags committed on the same rising edge,
// so a dependent instruction on the next cycle sees the new value without a
// stall. Taken branches raise a registered br_taken/br_addr pulse and discard
// the next FLUSH_CYC instruction slots. HALT parks the stage until reset.
// Ports: clk, rst (async, active-high), bus (dec_exec_if.slave),
//        [dbg_idx in, dbg_data out] when DEC_EXEC_DBG_EN is defined.
// Parameters: DATA_W (data width), FLUSH_CYC (slots discarded after branch).
// Optional feature macro: DEC_EXEC_DBG_EN.
// -----------------------------------------------------------------------------
module dec_exec import cpu_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  dec_exec_if.slave         bus
`ifdef DEC_EXEC_DBG_EN
  ,
  input  logic [1:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  localparam int                CNT_W      = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0]  FLUSH_INIT = CNT_W'(FLUSH_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_br_taken;
  logic [7:0]          r_br_addr;
  logic                r_wb_en;
  logic [1:0]          r_wb_idx;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_zero;
  logic                r_carry;
  logic                r_halted;
  logic                r_illegal;

  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W:0]     w_sum;
  logic                w_exec;
  logic                w_we;
  logic [1:0]          w_wa;
  logic [DATA_W-1:0]   w_wd;
  logic                w_upd_carry;
  logic                w_carry;
  logic                w_branch;
  logic                w_halt;
  logic                w_ill;

  regfile4x8 #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_ra_idx  (bus.Rs),
    .o_ra_data (w_rs_data),
    .i_rb_idx  (bus.Rt),
    .o_rb_data (w_rt_data),
    .i_we      (w_we),
    .i_wa      (w_wa),
    .i_wd      (w_wd)
`ifdef DEC_EXEC_DBG_EN
    ,
    .i_rc_idx  (dbg_idx),
    .o_rc_data (dbg_data)
`endif
  );

  // Decode and ALU: everything here is gated by w_exec, so FLUSH/HALT slots
  // produce no write, no flag update and no pulse.
  always_comb begin
    w_exec      = (r_state == ST_RUN) && bus.in_valid;
    w_imm       = DATA_W'(bus.imm);
    w_sum       = '0;
    w_we        = 1'b0;
    w_wa        = bus.Rd;
    w_wd        = '0;
    w_upd_carry = 1'b0;
    w_carry     = r_carry;
    w_branch    = 1'b0;
    w_halt      = 1'b0;
    w_ill       = 1'b0;
    if (w_exec) begin
      case (bus.Op)
        OP_NOP: begin
          w_we = 1'b0;
        end
        OP_ADD: begin
          w_sum       = {1'b0, w_rs_data} + {1'b0, w_rt_data};
          w_we        = 1'b1;
          w_wd        = w_sum[DATA_W-1:0];
          w_upd_carry = 1'b1;
          w_carry     = w_sum[DATA_W];
        end
        OP_SUB: begin
          w_we        = 1'b1;
          w_wd        = w_rs_data - w_rt_data;
          w_upd_carry = 1'b1;
          w_carry     = (w_rs_data < w_rt_data);
        end
        OP_AND: begin
          w_we        = 1'b1;
          w_wd        = w_rs_data & w_rt_data;
          w_upd_carry = 1'b1;
          w_carry     = 1'b0;
        end
        OP_OR: begin
          w_we        = 1'b1;
          w_wd        = w_rs_data | w_rt_data;
          w_upd_carry = 1'b1;
          w_carry     = 1'b0;
        end
        OP_XOR: begin
          w_we        = 1'b1;
          w_wd        = w_rs_data ^ w_rt_data;
          w_upd_carry = 1'b1;
          w_carry     = 1'b0;
        end
        OP_LI: begin
          // Immediate forms write Rt; LI leaves carry alone.
          w_we = 1'b1;
          w_wa = bus.Rt;
          w_wd = w_imm;
        end
        OP_ADDI: begin
          w_sum       = {1'b0, w_rs_data} + {1'b0, w_imm};
          w_we        = 1'b1;
          w_wa        = bus.Rt;
          w_wd        = w_sum[DATA_W-1:0];
          w_upd_carry = 1'b1;
          w_carry     = w_sum[DATA_W];
        end
        OP_BEQ: begin
          w_branch = (w_rs_data == w_rt_data);
        end
        OP_JMP: begin
          w_branch = 1'b1;
        end
        OP_HALT: begin
          w_halt = 1'b1;
        end
        default: begin
          w_ill = op_is_illegal(bus.Op);
        end
      endcase
    end else begin
      w_we = 1'b0;
    end
  end

  // Control FSM: RUN executes, FLUSH counts down discarded slots, HALT sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_branch) begin
            r_state <= (FLUSH_CYC == 0) ? ST_RUN : ST_FLUSH;
            r_cnt   <= FLUSH_INIT;
          end else if (w_halt) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          // The edge on which the counter reaches zero also re-enters RUN.
          if (r_cnt <= CNT_ONE) begin
            r_state <= ST_RUN;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt   <= r_cnt - CNT_ONE;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Registered outputs: pulses, writeback copy and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_taken <= 1'b0;
      r_br_addr  <= 8'h00;
      r_wb_en    <= 1'b0;
      r_wb_idx   <= 2'd0;
      r_wb_data  <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_br_taken <= w_branch;
      r_wb_en    <= w_we;
      r_illegal  <= w_ill;
      r_halted   <= (r_state == ST_HALT) || w_halt;
      if (w_branch) begin
        r_br_addr <= bus.imm;
      end
      if (w_we) begin
        r_wb_idx  <= w_wa;
        r_wb_data <= w_wd;
        r_zero    <= (w_wd == '0);
      end
      if (w_upd_carry) begin
        r_carry <= w_carry;
      end
    end
  end

  assign bus.br_taken = r_br_taken;
  assign bus.br_addr  = r_br_addr;
  assign bus.wb_en    = r_wb_en;
  assign bus.wb_idx   = r_wb_idx;
  assign bus.wb_data  = r_wb_data;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_carry;
  assign bus.halted   = r_halted;
  assign bus.illegal  = r_illegal;

endmodule

// File: doc/dec_exec.md
DEC_EXEC -- requirements
Module: dec_exec

Interface
REQ-001 Parameter DATA_W, default 8: register and ALU data width.
REQ-002 Parameter FLUSH_CYC, default 2: instruction slots discarded after a taken branch, covering address-generator plus ROM latency.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  Op/Rs/Rt/Rd/imm hold a fetched instruction this cycle.
REQ-006 Op  in  4  opcode field.
REQ-007 Rs, Rt, Rd  in  2 each  register index fields.
REQ-008 imm  in  8  immediate / branch target (overlaps Rd bits).
REQ-009 br_taken  out  1  one-cycle pulse requesting PC load.
REQ-010 br_addr  out  8  PC load target, valid with br_taken.
REQ-011 wb_en, wb_idx[1:0], wb_data[DATA_W-1:0]  out  registered copy of the last register write.
REQ-012 zero, carry  out  1 each  ALU flags.
REQ-013 halted  out  1  high while in HALT.
REQ-014 illegal  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-015 Opcodes: 0 NOP; 1 ADD Rd=Rs+Rt; 2 SUB Rd=Rs-Rt; 3 AND; 4 OR; 5 XOR; 6 LI Rt=imm; 7 ADDI Rt=Rs+imm; 8 BEQ if Rs==Rt branch to imm; 9 JMP to imm; F HALT; A-E illegal.
REQ-016 FSM states RUN, FLUSH, HALT; instructions execute only in RUN with in_valid=1.
REQ-017 Execution is single-cycle: operands are read combinationally, and the result and flags are written at the same clock edge.
REQ-018 Back-to-back dependent instructions SHALL see the previous write with no stall.
REQ-019 Arithmetic: ADD/ADDI carry = bit DATA_W of the unsigned sum; SUB carry = borrow (Rs<Rt unsigned); logic ops clear carry; zero = (result==0); LI sets zero only.
REQ-020 NOP, BEQ, JMP and illegal opcodes leave registers and flags unchanged; illegal also pulses illegal.
REQ-021 A taken BEQ/JMP pulses br_taken with br_addr=imm the next cycle, then RUN->FLUSH with counter=FLUSH_CYC.
REQ-022 In FLUSH, each cycle decrements the counter regardless of in_valid; instructions are ignored; counter reaching 0 returns to RUN.
REQ-023 HALT: RUN->HALT; halted=1; all inputs ignored until reset.
REQ-024 An untaken BEQ behaves as NOP; BEQ with Rs==Rt as the same index is always taken.
REQ-025 wb_en pulses one cycle per register write; wb_idx/wb_data hold their last value otherwise.

Reset
REQ-026 rst=1 immediately forces state RUN, flush counter 0, all four registers 0, zero=0, carry=0, br_taken=0, br_addr=0, wb_en=0, wb_idx=0, wb_data=0, halted=0, illegal=0.
REQ-027 Reset asserted during FLUSH or HALT SHALL abort it with no residual pulse after release.

Configuration
REQ-028 Macro DEC_EXEC_DBG_EN, when defined, adds input dbg_idx[1:0] and output dbg_data[DATA_W-1:0], a combinational read of register dbg_idx.
REQ-029 Without DEC_EXEC_DBG_EN these ports do not exist and behaviour is otherwise identical.

Structure
REQ-030 Shared package cpu_pkg holds the opcode constants, the FSM state enum and DATA_W default.
REQ-031 The register file is sub-module regfile4x8: two combinational read ports, one synchronous write port, async reset.

Verification
REQ-032 LI R1,0x05; LI R2,0x03; ADD R3=R1+R2 -> wb R3=0x08, zero=0, carry=0.
REQ-033 LI R1,0xFF; LI R2,0x01; ADD R0=R1+R2 -> R0=0x00, zero=1, carry=1; SUB R0=R2-R1 -> R0=0x02, carry=1.
REQ-034 JMP 0x20 followed by two valid ADDs -> br_taken pulse with br_addr=0x20, both ADDs discarded (wb_en=0), third instruction executes.
REQ-035 BEQ R1,R2,0x10 with R1!=R2 -> no br_taken, next instruction executes; with R1==R2 -> br_taken, br_addr=0x10.
REQ-036 Op=0xC -> illegal pulse, no write; HALT then ADD -> halted=1, no write until rst.
REQ-037 rst pulsed mid-FLUSH -> all outputs at reset values; first instruction after release executes.
